// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// Grants one word per frame, tracks tx_busy through the frame, aborts on a silent transmitter.
module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int BUSY_TMO = 64
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ack,
  input  logic                      tx_busy,
  output logic                      send_en,
  output logic [DATA_W-1:0]         send_data,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      active,
  output logic                      tx_timeout
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMO_W = $clog2(BUSY_TMO);
  localparam logic [IDX_W:0]   N_REQ_W  = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_IDLE} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_n;
  logic [DATA_W-1:0]  send_data_n;
  logic [IDX_W-1:0]   grant_id_n;
  logic [N_REQ-1:0]   req_ack_n;
  logic               send_en_n;
  logic               tx_timeout_n;

  logic [IDX_W-1:0]   sel;
  logic               found;
  logic [IDX_W:0]     cand;

  // Rotating priority search starting at rr_ptr; first valid requester wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= N_REQ_W) cand = cand - N_REQ_W;
      if (!found && req_valid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_n      = state;
    rr_ptr_n     = rr_ptr;
    tmo_cnt_n    = tmo_cnt;
    send_data_n  = send_data;
    grant_id_n   = grant_id;
    req_ack_n    = '0;
    send_en_n    = 1'b0;
    tx_timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (found && !tx_busy) begin
          send_data_n    = req_data[int'(sel)*DATA_W +: DATA_W];
          grant_id_n     = sel;
          req_ack_n[sel] = 1'b1;
          rr_ptr_n       = (sel == LAST_IDX) ? '0 : sel + 1'b1;
          state_n        = LOAD;
        end
      end
      LOAD: begin
        send_en_n = 1'b1;
        tmo_cnt_n = '0;
        state_n   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_n = WAIT_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tx_timeout_n = 1'b1;
          state_n      = IDLE;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (!tx_busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      tmo_cnt    <= '0;
      send_data  <= '0;
      grant_id   <= '0;
      req_ack    <= '0;
      send_en    <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_ptr_n;
      tmo_cnt    <= tmo_cnt_n;
      send_data  <= send_data_n;
      grant_id   <= grant_id_n;
      req_ack    <= req_ack_n;
      send_en    <= send_en_n;
      tx_timeout <= tx_timeout_n;
    end
  end

  assign active = (state != IDLE);

endmodule
